// File: rtl/pwm_counter.sv
// pwm_counter: prescaled up/down period counter with shadowed period, prescale and direction.
// Latency: count_val, period_act and wrap are registered and change one clk after the tick that causes them.
// Backpressure: none; en holds the counter and prescaler, count_reset restarts it synchronously.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   en                count enable (low: counter, prescaler and shadows hold)
//   count_reset       one-cycle synchronous restart, wins over en and over a tick
//   period[15:0]      requested period in ticks (taken into the shadow only on load events)
//   prescale[7:0]     requested divider, one tick every prescale+1 clks
//   dir               requested direction, 0 = up, 1 = down
//   count_val[15:0]   current count
//   period_act[15:0]  shadowed period currently in force
//   wrap              one-clk pulse in the cycle count_val takes its wrapped value
module pwm_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        count_reset,
  input  logic [15:0] period,
  input  logic [7:0]  prescale,
  input  logic        dir,
  output logic [15:0] count_val,
  output logic [15:0] period_act,
  output logic        wrap
);

  logic [15:0] count_q, count_d;
  logic [15:0] period_act_q, period_act_d;
  logic [7:0]  prescale_act_q, prescale_act_d;
  logic        dir_act_q, dir_act_d;
  logic [7:0]  presc_cnt_q, presc_cnt_d;
  logic        wrap_q, wrap_d;
  logic        en_prev_q;

  logic        en_rise;
  logic [15:0] eff_period;
  logic [7:0]  eff_prescale;
  logic        eff_dir;
  logic        tick;
  logic        degen;
  logic        wrap_ev;
  logic [15:0] start_val;

  // en_prev_q resets low, so the first clk after reset with en high counts as an
  // enable edge and loads the shadows.
  assign en_rise = en & ~en_prev_q;

  // On an enable edge the freshly requested settings govern this very cycle, so a
  // resumed count is judged (and clamped if needed) against the new period.
  assign eff_period   = en_rise ? period   : period_act_q;
  assign eff_prescale = en_rise ? prescale : prescale_act_q;
  assign eff_dir      = en_rise ? dir      : dir_act_q;

  // >= rather than == so a prescaler left above a smaller new divider still ticks.
  assign tick  = en & (presc_cnt_q >= eff_prescale);
  assign degen = (eff_period < 16'd2);

  // Wrap condition covers both the natural period end and the out-of-range clamp.
  always_comb begin
    wrap_ev = 1'b0;
    if (degen) begin
      wrap_ev = 1'b1;
    end else if (!eff_dir) begin
      wrap_ev = (count_q >= (eff_period - 16'd1));
    end else begin
      wrap_ev = (count_q == 16'd0) || (count_q >= eff_period);
    end
  end

  // Every wrap and every restart reloads the shadows, so the value the count lands on
  // is always derived from the newly requested period and direction.
  assign start_val = (dir && (period >= 16'd2)) ? (period - 16'd1) : 16'd0;

  always_comb begin
    count_d        = count_q;
    period_act_d   = period_act_q;
    prescale_act_d = prescale_act_q;
    dir_act_d      = dir_act_q;
    presc_cnt_d    = presc_cnt_q;
    wrap_d         = 1'b0;

    if (count_reset) begin
      period_act_d   = period;
      prescale_act_d = prescale;
      dir_act_d      = dir;
      presc_cnt_d    = 8'd0;
      count_d        = start_val;
    end else if (en) begin
      presc_cnt_d = tick ? 8'd0 : (presc_cnt_q + 8'd1);
      if (en_rise || (tick && wrap_ev)) begin
        period_act_d   = period;
        prescale_act_d = prescale;
        dir_act_d      = dir;
      end
      if (tick) begin
        wrap_d = wrap_ev;
        if (wrap_ev) begin
          count_d = start_val;
        end else if (eff_dir) begin
          count_d = count_q - 16'd1;
        end else begin
          count_d = count_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q        <= 16'd0;
      period_act_q   <= 16'd0;
      prescale_act_q <= 8'd0;
      dir_act_q      <= 1'b0;
      presc_cnt_q    <= 8'd0;
      wrap_q         <= 1'b0;
      en_prev_q      <= 1'b0;
    end else begin
      count_q        <= count_d;
      period_act_q   <= period_act_d;
      prescale_act_q <= prescale_act_d;
      dir_act_q      <= dir_act_d;
      presc_cnt_q    <= presc_cnt_d;
      wrap_q         <= wrap_d;
      en_prev_q      <= en;
    end
  end

  assign count_val  = count_q;
  assign period_act = period_act_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_pwm_counter.sv
// tb_pwm_counter: directed stimulus for pwm_counter with hand-computed expectations.
// Latency: outputs sampled 1 ns after each rising clk edge.
// Backpressure: not applicable.
module tb_pwm_counter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        count_reset;
  logic [15:0] period;
  logic [7:0]  prescale;
  logic        dir;
  logic [15:0] count_val;
  logic [15:0] period_act;
  logic        wrap;

  int n_pass;
  int n_total;

  pwm_counter dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .count_reset(count_reset),
    .period     (period),
    .prescale   (prescale),
    .dir        (dir),
    .count_val  (count_val),
    .period_act (period_act),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  int up_c[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  int up_w[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  int dn_c[8] = '{0, 4, 3, 2, 1, 0, 7, 6};
  int dn_w[8] = '{0, 1, 0, 0, 0, 0, 1, 0};
  int dn_p[8] = '{5, 5, 5, 5, 5, 5, 8, 8};

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    en = 1'b0;
    count_reset = 1'b0;
    period = 16'd4;
    prescale = 8'd0;
    dir = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_count", count_val, 16'd0);
    chk("rst_period", period_act, 16'd0);
    chk("rst_wrap", {15'd0, wrap}, 16'd0);

    // Up count, period 4, no prescale; first clk after release is an enable edge
    en = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("up_count", count_val, up_c[i][15:0]);
      chk("up_wrap", {15'd0, wrap}, up_w[i][15:0]);
    end
    chk("up_period", period_act, 16'd4);

    // Prescale: period 3, prescale 2, loaded by a restart
    period = 16'd3;
    prescale = 8'd2;
    count_reset = 1'b1;
    tick();
    count_reset = 1'b0;
    chk("psc_restart_count", count_val, 16'd0);
    chk("psc_restart_wrap", {15'd0, wrap}, 16'd0);
    chk("psc_period", period_act, 16'd3);
    for (int i = 1; i <= 18; i++) begin
      tick();
      chk("psc_count", count_val, 16'((i / 3) % 3));
      chk("psc_wrap", {15'd0, wrap}, (i % 9 == 0) ? 16'd1 : 16'd0);
    end

    // count_reset together with en at count 6, period 10
    period = 16'd10;
    prescale = 8'd0;
    count_reset = 1'b1;
    tick();
    count_reset = 1'b0;
    repeat (6) tick();
    chk("cr_pre_count", count_val, 16'd6);
    count_reset = 1'b1;
    tick();
    count_reset = 1'b0;
    chk("cr_count", count_val, 16'd0);
    chk("cr_wrap", {15'd0, wrap}, 16'd0);
    tick();
    chk("cr_next_count", count_val, 16'd1);

    // en low holds everything
    en = 1'b0;
    tick();
    tick();
    chk("hold_count", count_val, 16'd1);
    chk("hold_wrap", {15'd0, wrap}, 16'd0);

    // Down count, period 5, period request changed to 8 mid-period
    dir = 1'b1;
    period = 16'd5;
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("dn_count", count_val, dn_c[i][15:0]);
      chk("dn_wrap", {15'd0, wrap}, dn_w[i][15:0]);
      chk("dn_period", period_act, dn_p[i][15:0]);
      if (i == 2) period = 16'd8;
    end

    // Re-enable with a shorter period clamps the out-of-range count and wraps
    en = 1'b0;
    tick();
    chk("clamp_hold", count_val, 16'd6);
    period = 16'd3;
    dir = 1'b0;
    en = 1'b1;
    tick();
    chk("clamp_count", count_val, 16'd0);
    chk("clamp_wrap", {15'd0, wrap}, 16'd1);
    chk("clamp_period", period_act, 16'd3);
    tick();
    chk("clamp_next", count_val, 16'd1);
    chk("clamp_next_wrap", {15'd0, wrap}, 16'd0);

    // Degenerate period 1 with prescale 1
    period = 16'd1;
    prescale = 8'd1;
    count_reset = 1'b1;
    tick();
    count_reset = 1'b0;
    chk("deg_restart_wrap", {15'd0, wrap}, 16'd0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("deg_count", count_val, 16'd0);
      chk("deg_wrap", {15'd0, wrap}, (i % 2 == 0) ? 16'd1 : 16'd0);
    end

    // Asynchronous reset at count 3
    period = 16'd10;
    prescale = 8'd0;
    count_reset = 1'b1;
    tick();
    count_reset = 1'b0;
    repeat (3) tick();
    chk("mid_pre_count", count_val, 16'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_count", count_val, 16'd0);
    chk("mid_rst_period", period_act, 16'd0);
    chk("mid_rst_wrap", {15'd0, wrap}, 16'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_count", count_val, 16'd1);
    chk("post_rst_wrap", {15'd0, wrap}, 16'd0);
    chk("post_rst_period", period_act, 16'd10);
    tick();
    chk("post_rst_count2", count_val, 16'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
